// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of the 4-bit ALU: accepts load/op commands, keeps the accumulator,
// and returns results over valid/ready. Define CMD_SKID_EN to add a one-entry command skid buffer.
module alu_cmd_sequencer #(
    parameter int unsigned DW  = 4,
    parameter int unsigned OCW = 3,
    parameter int unsigned CW  = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic           cmd_load,
    input  logic [OCW-1:0] cmd_oc,
    input  logic [DW-1:0]  cmd_data,
    output logic [OCW-1:0] alu_oc,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    input  logic [DW-1:0]  alu_f,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [DW-1:0]  res_data,
    output logic           res_zero,
    output logic [CW-1:0]  op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [DW-1:0]  acc_q, acc_d;
    logic [DW-1:0]  op_b_q, op_b_d;
    logic [OCW-1:0] op_oc_q, op_oc_d;
    logic [DW-1:0]  res_data_q, res_data_d;
    logic           res_zero_q, res_zero_d;
    logic           res_valid_q, res_valid_d;
    logic [CW-1:0]  op_count_q, op_count_d;
    logic           cmd_ready_q, cmd_ready_d;

    logic           accept_c;
    logic           disp_v_c;
    logic           disp_load_c;
    logic [OCW-1:0] disp_oc_c;
    logic [DW-1:0]  disp_data_c;

`ifdef CMD_SKID_EN
    logic           skid_full_q, skid_full_d;
    logic           skid_load_q, skid_load_d;
    logic [OCW-1:0] skid_oc_q, skid_oc_d;
    logic [DW-1:0]  skid_data_q, skid_data_d;
    logic           skid_wr_c;
`endif

    assign accept_c = cmd_valid && cmd_ready_q;

    // Next-state: a "dispatch" starts a command either from the port or from the skid entry.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        op_b_d      = op_b_q;
        op_oc_d     = op_oc_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        op_count_d  = op_count_q;
        disp_v_c    = 1'b0;
        disp_load_c = cmd_load;
        disp_oc_c   = cmd_oc;
        disp_data_c = cmd_data;
`ifdef CMD_SKID_EN
        skid_full_d = skid_full_q;
        skid_load_d = skid_load_q;
        skid_oc_d   = skid_oc_q;
        skid_data_d = skid_data_q;
        skid_wr_c   = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                disp_v_c = accept_c;
            end
            EXEC: begin
                acc_d       = alu_f;
                res_data_d  = alu_f;
                res_valid_d = 1'b1;
                state_d     = RESP;
`ifdef CMD_SKID_EN
                skid_wr_c   = accept_c;
`endif
            end
            RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    op_count_d  = op_count_q + CW'(1);
                    state_d     = IDLE;
`ifdef CMD_SKID_EN
                    if (skid_full_q) begin
                        disp_v_c    = 1'b1;
                        disp_load_c = skid_load_q;
                        disp_oc_c   = skid_oc_q;
                        disp_data_c = skid_data_q;
                        skid_full_d = 1'b0;
                    end else begin
                        disp_v_c = accept_c;
                    end
`else
                    disp_v_c = accept_c;
`endif
                end else begin
`ifdef CMD_SKID_EN
                    skid_wr_c = accept_c;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (disp_v_c) begin
            op_oc_d = disp_oc_c;
            op_b_d  = disp_data_c;
            if (disp_load_c) begin
                acc_d       = disp_data_c;
                res_data_d  = disp_data_c;
                res_valid_d = 1'b1;
                state_d     = RESP;
            end else begin
                state_d = EXEC;
            end
        end

`ifdef CMD_SKID_EN
        if (skid_wr_c) begin
            skid_full_d = 1'b1;
            skid_load_d = cmd_load;
            skid_oc_d   = cmd_oc;
            skid_data_d = cmd_data;
        end
        cmd_ready_d = !skid_full_d;
`else
        cmd_ready_d = (state_d == IDLE);
`endif
        res_zero_d = (res_data_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            op_b_q      <= '0;
            op_oc_q     <= '0;
            res_data_q  <= '0;
            res_zero_q  <= 1'b1;
            res_valid_q <= 1'b0;
            op_count_q  <= '0;
            cmd_ready_q <= 1'b1;
`ifdef CMD_SKID_EN
            skid_full_q <= 1'b0;
            skid_load_q <= 1'b0;
            skid_oc_q   <= '0;
            skid_data_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            op_b_q      <= op_b_d;
            op_oc_q     <= op_oc_d;
            res_data_q  <= res_data_d;
            res_zero_q  <= res_zero_d;
            res_valid_q <= res_valid_d;
            op_count_q  <= op_count_d;
            cmd_ready_q <= cmd_ready_d;
`ifdef CMD_SKID_EN
            skid_full_q <= skid_full_d;
            skid_load_q <= skid_load_d;
            skid_oc_q   <= skid_oc_d;
            skid_data_q <= skid_data_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign alu_oc    = op_oc_q;
    assign alu_a     = acc_q;
    assign alu_b     = op_b_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_zero  = res_zero_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: directed scenarios then random commands against an
// accumulator model; a negedge monitor checks every presented result.
module tb_alu_cmd_sequencer;

    localparam int unsigned DW  = 4;
    localparam int unsigned OCW = 3;
    localparam int unsigned CW  = 2;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          z;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic           cmd_load = 1'b0;
    logic [OCW-1:0] cmd_oc = '0;
    logic [DW-1:0]  cmd_data = '0;
    logic [OCW-1:0] alu_oc;
    logic [DW-1:0]  alu_a;
    logic [DW-1:0]  alu_b;
    logic [DW-1:0]  alu_f;
    logic           res_valid;
    logic           res_ready = 1'b0;
    logic [DW-1:0]  res_data;
    logic           res_zero;
    logic [CW-1:0]  op_count;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    logic [DW-1:0] m_acc = '0;
    int   exp_count = 0;
    bit   rr_auto = 1'b0;
    bit   hold = 1'b0;

    alu_cmd_sequencer #(.DW(DW), .OCW(OCW), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_load  (cmd_load),
        .cmd_oc    (cmd_oc),
        .cmd_data  (cmd_data),
        .alu_oc    (alu_oc),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_f     (alu_f),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_zero  (res_zero),
        .op_count  (op_count)
    );

    // ALU stand-in: even opcodes add (b subtracts when oc[2]), odd opcodes xor.
    function automatic logic [DW-1:0] alu_model(input logic [OCW-1:0] oc,
                                                 input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (oc[0])      return a ^ b;
        else if (oc[2]) return a - b;
        else            return a + b;
    endfunction

    assign alu_f = alu_model(alu_oc, alu_a, alu_b);

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Presents a command until accepted; returns just after the accepting edge (+1).
    task automatic send_cmd(input logic ld, input logic [OCW-1:0] oc, input logic [DW-1:0] d,
                            output int waits);
        bit   rdy;
        exp_t e;
        waits     = 0;
        cmd_valid = 1'b1;
        cmd_load  = ld;
        cmd_oc    = oc;
        cmd_data  = d;
        forever begin
            @(negedge clk);
            rdy = cmd_ready;
            @(posedge clk);
            if (rdy) break;
            waits++;
            if (waits > 50) begin
                check("accept_timeout", 32'(waits), 32'd0);
                break;
            end
        end
        if (waits <= 50) begin
            m_acc = ld ? d : alu_model(oc, m_acc, d);
            e.d   = m_acc;
            e.z   = (m_acc == '0);
            exp_q.push_back(e);
        end
        #1;
        cmd_valid = 1'b0;
    endtask

    // Random downstream backpressure when enabled.
    initial forever begin
        @(posedge clk);
        #1;
        if (rr_auto) res_ready = ($urandom_range(0, 2) != 0);
    end

    // Monitor: every cycle a result is shown it must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (hold) check("res_valid_held", 32'(res_valid), 32'd1);
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    check("res_valid_no_pending", 32'(res_valid), 32'd0);
                end else begin
                    e = exp_q[0];
                    check("res_data", 32'(res_data), 32'(e.d));
                    check("res_zero", 32'(res_zero), 32'(e.z));
                    if (res_ready) begin
                        check("op_count", 32'(op_count), 32'(exp_count));
                        exp_q.pop_front();
                        exp_count = (exp_count + 1) % (1 << CW);
                    end
                end
            end
            hold = res_valid && !res_ready;
        end
    end

    initial begin
        int   w;
        exp_t dropped;

        repeat (3) @(posedge clk);
        #1;
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_zero", 32'(res_zero), 32'd1);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_alu_oc", 32'(alu_oc), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load 3: result one edge after accept.
        res_ready = 1'b1;
        send_cmd(1'b1, 3'b000, 4'h3, w);
        check("load_valid_n1", 32'(res_valid), 32'd1);
        check("load_data", 32'(res_data), 32'h3);
        check("load_zero", 32'(res_zero), 32'd0);
        check("load_alu_a", 32'(alu_a), 32'h3);
        @(posedge clk);
        #1;
        check("load_op_count", 32'(op_count), 32'd1);

        // ALU op 3 + 5 with opcode 010.
        send_cmd(1'b0, 3'b010, 4'h5, w);
        check("exec_alu_oc", 32'(alu_oc), 32'b010);
        check("exec_alu_a", 32'(alu_a), 32'h3);
        check("exec_alu_b", 32'(alu_b), 32'h5);
        check("exec_no_valid", 32'(res_valid), 32'd0);
        @(posedge clk);
        #1;
        check("op_valid_n2", 32'(res_valid), 32'd1);
        check("op_data", 32'(res_data), 32'h8);

        // F + 1 wraps to zero.
        send_cmd(1'b1, 3'b000, 4'hF, w);
        send_cmd(1'b0, 3'b010, 4'h1, w);
        @(posedge clk);
        #1;
        check("wrap_data", 32'(res_data), 32'h0);
        check("wrap_zero", 32'(res_zero), 32'd1);
        @(posedge clk);
        #1;
        check("idle_after_wrap", 32'(res_valid), 32'd0);

        // Backpressure for 5 cycles with a new command waiting.
        res_ready = 1'b0;
        send_cmd(1'b1, 3'b000, 4'hA, w);
`ifdef CMD_SKID_EN
        cmd_valid = 1'b0;
`else
        cmd_valid = 1'b1;
`endif
        cmd_load = 1'b1;
        cmd_data = 4'h6;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(res_valid), 32'd1);
            check("bp_data", 32'(res_data), 32'hA);
`ifdef CMD_SKID_EN
            check("bp_cmd_ready", 32'(cmd_ready), 32'd1);
`else
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
`endif
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
        send_cmd(1'b1, 3'b000, 4'h6, w);
`ifdef CMD_SKID_EN
        check("bp_accept_wait", 32'(w), 32'd0);
`else
        check("bp_accept_wait", 32'(w), 32'd1);
`endif
        @(posedge clk);
        #1;

        // Reset during EXEC drops the command and clears state.
        send_cmd(1'b0, 3'b010, 4'h4, w);
        rst_n = 1'b0;
        dropped = exp_q.pop_back();
        @(posedge clk);
        #1;
        check("rst_exec_valid", 32'(res_valid), 32'd0);
        check("rst_exec_acc", 32'(alu_a), 32'd0);
        check("rst_exec_count", 32'(op_count), 32'd0);
        check("rst_exec_ready", 32'(cmd_ready), 32'd1);
        m_acc     = '0;
        exp_count = 0;
        rst_n     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_exec_no_result", 32'(res_valid), 32'd0);

        // Four handshakes wrap a 2-bit counter.
        for (int i = 0; i < 4; i++) send_cmd(1'b1, 3'b000, 4'(i + 1), w);
        @(posedge clk);
        #1;
        check("count_wrap", 32'(op_count), 32'd0);

        // Random traffic.
        rr_auto = 1'b1;
        for (int i = 0; i < 120; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
            send_cmd($urandom_range(0, 3) == 0, OCW'($urandom), DW'($urandom), w);
        end

        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
